// File: rtl/pipe_reg.sv
// Elastic valid/ready pipeline register, DEPTH stages of forward or skid type.
// Occupancy counter tracks words held; flush clears every stage in one edge.
module pipe_reg #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 2,
  parameter int               MODE        = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = (DEPTH > 0) ? $clog2(2*DEPTH+1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } stage_e;

  if (DEPTH == 0) begin : g_wire
    assign valid_o = valid_i;
    assign data_o  = data_i;
    assign ready_o = ready_i;
    assign count_o = '0;
  end else begin : g_pipe
    logic [DEPTH:0]            vld;
    logic [DEPTH:0][WIDTH-1:0] dat;
    logic [DEPTH:0]            rdy;
    logic [DEPTH-1:0]          busy;
    logic [CNT_W-1:0]          cnt_q;
    logic                      in_hs;
    logic                      out_hs;

    assign vld[0]  = valid_i;
    assign dat[0]  = data_i;
    assign ready_o = rdy[0];
    assign valid_o = vld[DEPTH];
    assign data_o  = dat[DEPTH];
    assign count_o = cnt_q;
    assign in_hs   = valid_i && rdy[0];
    assign out_hs  = vld[DEPTH] && ready_i;

    // Forward stages pass ready through; skid stages only look at their flop.
    always_comb begin
      rdy        = '0;
      rdy[DEPTH] = ready_i;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        rdy[k] = !busy[k] || (MODE == 0 && rdy[k+1]);
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (MODE == 1) begin : g_skid
        stage_e           st_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             acc;
        logic             dn;

        assign acc = vld[i] && (st_q != FULL);
        assign dn  = (st_q != EMPTY) && rdy[i+1];

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            st_q   <= EMPTY;
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
          end else if (flush_i) begin
            st_q   <= EMPTY;
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
          end else begin
            case (st_q)
              EMPTY: begin
                if (acc) begin
                  st_q   <= HALF;
                  main_q <= dat[i];
                end
              end
              HALF: begin
                if (acc && dn) begin
                  main_q <= dat[i];
                end else if (acc) begin
                  st_q   <= FULL;
                  skid_q <= dat[i];
                end else if (dn) begin
                  st_q   <= EMPTY;
                end
              end
              FULL: begin
                if (dn) begin
                  st_q   <= HALF;
                  main_q <= skid_q;
                end
              end
              default: st_q <= EMPTY;
            endcase
          end
        end

        assign busy[i]  = (st_q == FULL);
        assign vld[i+1] = (st_q != EMPTY);
        assign dat[i+1] = main_q;
      end else begin : g_fwd
        logic             v_q;
        logic [WIDTH-1:0] d_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            v_q <= 1'b0;
            d_q <= RESET_VALUE;
          end else if (flush_i) begin
            v_q <= 1'b0;
            d_q <= RESET_VALUE;
          end else if (rdy[i]) begin
            v_q <= vld[i];
            if (vld[i]) d_q <= dat[i];
          end
        end

        assign busy[i]  = v_q;
        assign vld[i+1] = v_q;
        assign dat[i+1] = d_q;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (flush_i) begin
        cnt_q <= '0;
      end else begin
        unique case (1'b1)
          in_hs && !out_hs: cnt_q <= cnt_q + 1'b1;
          out_hs && !in_hs: cnt_q <= cnt_q - 1'b1;
          default:          cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg: skid, forward and pass-through configurations.
// Expected words are queued on input handshakes and popped on output handshakes.
module tb_pipe_reg;

  logic clk;
  logic rst_n;

  logic       a_fl, a_vi, a_ro, a_vo, a_ri;
  logic [7:0] a_di, a_do;
  logic [2:0] a_cnt;

  logic       b_fl, b_vi, b_ro, b_vo, b_ri;
  logic [7:0] b_di, b_do;
  logic [2:0] b_cnt;

  logic       c_fl, c_vi, c_ro, c_vo, c_ri;
  logic [7:0] c_di, c_do;
  logic [0:0] c_cnt;

  logic       d_fl, d_vi, d_ro, d_vo, d_ri;
  logic [7:0] d_di, d_do;
  logic [3:0] d_cnt;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_d[$];

  int   n_chk;
  int   n_err;
  int   acc;
  logic hs;
  logic b_mon;

  pipe_reg #(.WIDTH(8), .DEPTH(2), .MODE(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_fl),
    .valid_i(a_vi), .ready_o(a_ro), .data_i(a_di),
    .valid_o(a_vo), .ready_i(a_ri), .data_o(a_do),
    .count_o(a_cnt)
  );

  pipe_reg #(.WIDTH(8), .DEPTH(3), .MODE(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_fl),
    .valid_i(b_vi), .ready_o(b_ro), .data_i(b_di),
    .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do),
    .count_o(b_cnt)
  );

  pipe_reg #(.WIDTH(8), .DEPTH(0), .MODE(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(c_fl),
    .valid_i(c_vi), .ready_o(c_ro), .data_i(c_di),
    .valid_o(c_vo), .ready_i(c_ri), .data_o(c_do),
    .count_o(c_cnt)
  );

  pipe_reg #(.WIDTH(8), .DEPTH(4), .MODE(1)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(d_fl),
    .valid_i(d_vi), .ready_o(d_ro), .data_i(d_di),
    .valid_o(d_vo), .ready_i(d_ri), .data_o(d_do),
    .count_o(d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      q_d.delete();
    end else begin
      if (a_vo && a_ri) begin
        chk("a_sb_nonempty", 32'(q_a.size() > 0), 1);
        if (q_a.size() > 0) chk("a_sb_data", a_do, q_a.pop_front());
      end
      if (a_fl) q_a.delete();
      else if (a_vi && a_ro) q_a.push_back(a_di);

      if (b_vo && b_ri) begin
        chk("b_sb_nonempty", 32'(q_b.size() > 0), 1);
        if (q_b.size() > 0) chk("b_sb_data", b_do, q_b.pop_front());
      end
      if (b_vi && b_ro) q_b.push_back(b_di);
      if (b_mon) begin
        chk("t3_cnt_max", 32'(b_cnt <= 3), 1);
        if (b_cnt == 3) chk("t3_rdy_track", b_ro, b_ri);
      end

      if (d_vo && d_ri) begin
        chk("d_sb_nonempty", 32'(q_d.size() > 0), 1);
        if (q_d.size() > 0) chk("d_sb_data", d_do, q_d.pop_front());
      end
      if (d_vi && d_ro) q_d.push_back(d_di);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    b_mon = 1'b0;
    rst_n = 1'b0;
    {a_fl, a_vi, a_ri, a_di} = '0;
    {b_fl, b_vi, b_ri, b_di} = '0;
    {c_fl, c_vi, c_ri, c_di} = '0;
    {d_fl, d_vi, d_ri, d_di} = '0;
    #3;
    chk("rst_a_vo", a_vo, 0);
    chk("rst_a_do", a_do, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_ro", a_ro, 1);
    chk("rst_b_ro", b_ro, 1);
    chk("rst_d_ro", d_ro, 1);
    #9 rst_n = 1'b1;
    tick();

    // back-to-back stream through the skid pipe
    a_ri = 1'b1;
    a_vi = 1'b1;
    a_di = 8'h01;
    tick();
    chk("t1_lat_n", a_vo, 0);
    for (int w = 2; w <= 16; w++) begin
      a_di = 8'(w);
      tick();
      if (w == 2) begin
        chk("t1_first_vo", a_vo, 1);
        chk("t1_first_do", a_do, 8'h01);
      end
      if (w == 8) chk("t1_cnt", a_cnt, 2);
      chk("t1_ready", a_ro, 1);
    end
    a_vi = 1'b0;
    repeat (4) tick();
    chk("t1_drain_cnt", a_cnt, 0);
    chk("t1_drain_q", q_a.size(), 0);

    // back-pressure fills both entries of both stages
    a_ri = 1'b0;
    a_vi = 1'b1;
    a_di = 8'hA0;
    acc = 0;
    repeat (8) begin
      @(negedge clk);
      hs = a_ro;
      tick();
      if (hs) begin
        acc++;
        a_di++;
      end
    end
    a_vi = 1'b0;
    chk("t2_accepted", acc, 4);
    chk("t2_ready_low", a_ro, 0);
    chk("t2_cnt", a_cnt, 4);
    a_ri = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t2_no_bubble", a_vo, 1);
    end
    @(negedge clk);
    chk("t2_empty", a_vo, 0);
    chk("t2_q", q_a.size(), 0);
    tick();

    // forward pipe with toggling ready_i
    b_mon = 1'b1;
    b_vi = 1'b1;
    b_di = 8'h10;
    b_ri = 1'b1;
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 20; cyc++) begin
      @(negedge clk);
      hs = b_ro;
      tick();
      if (hs) begin
        acc++;
        b_di++;
      end
      b_ri = ~b_ri;
    end
    b_vi = 1'b0;
    chk("t3_sent", acc, 20);
    b_ri = 1'b1;
    repeat (6) tick();
    b_mon = 1'b0;
    chk("t3_q", q_b.size(), 0);
    chk("t3_cnt_end", b_cnt, 0);

    // flush with three words held and a word offered
    a_ri = 1'b0;
    a_vi = 1'b1;
    a_di = 8'h31;
    acc = 0;
    for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
      @(negedge clk);
      hs = a_ro;
      tick();
      if (hs) begin
        acc++;
        a_di++;
      end
    end
    a_vi = 1'b0;
    chk("t4_held", a_cnt, 3);
    a_fl = 1'b1;
    a_vi = 1'b1;
    a_di = 8'h55;
    tick();
    a_fl = 1'b0;
    a_vi = 1'b0;
    chk("t4_vo", a_vo, 0);
    chk("t4_cnt", a_cnt, 0);
    chk("t4_do", a_do, 0);
    chk("t4_ro", a_ro, 1);
    a_ri = 1'b1;
    repeat (5) tick();
    chk("t4_no_55", a_vo, 0);

    // pass-through configuration
    repeat (20) begin
      c_vi = 1'($urandom_range(0, 1));
      c_ri = 1'($urandom_range(0, 1));
      c_di = 8'($urandom);
      #2;
      chk("t5_vo", c_vo, c_vi);
      chk("t5_do", c_do, c_di);
      chk("t5_ro", c_ro, c_ri);
      chk("t5_cnt", c_cnt, 0);
    end
    tick();

    // asynchronous reset mid-stream on the 4-deep skid pipe
    d_ri = 1'b0;
    d_vi = 1'b1;
    d_di = 8'h61;
    acc = 0;
    for (int cyc = 0; cyc < 20 && acc < 5; cyc++) begin
      @(negedge clk);
      hs = d_ro;
      tick();
      if (hs) begin
        acc++;
        d_di++;
      end
    end
    d_vi = 1'b0;
    chk("t6_cnt5", d_cnt, 5);
    chk("t6_vo_pre", d_vo, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_vo_async", d_vo, 0);
    chk("t6_cnt_async", d_cnt, 0);
    #10;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("t6_ro", d_ro, 1);
    d_ri = 1'b1;
    d_vi = 1'b1;
    d_di = 8'h7E;
    tick();
    d_vi = 1'b0;
    chk("t6_lat0", d_vo, 0);
    repeat (2) begin
      tick();
      chk("t6_latx", d_vo, 0);
    end
    tick();
    chk("t6_vo", d_vo, 1);
    chk("t6_do", d_do, 8'h7E);
    repeat (3) tick();
    chk("t6_q", q_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
